instruction_encoder: RTL and testbench

- Inverse of the decode stage: packs instruction fields into 32-bit words of the processor ISA and streams them into instruction memory at sequential word addresses.
- Sits between the test/boot loader (field source) and the instruction memory write port.
- Input handshake is valid/ready; output is a single registered write stage with memory backpressure.
- Stops after writing a word with the stop bit set, or when the memory region is full.

---
 rtl/instruction_encoder.sv | 246 ++++++++++++++++++++++++
 tb/tb_instruction_encoder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Packs instruction field bundles into 32-bit ISA words and streams them to
// instruction memory at sequential word addresses. Define CHECKSUM_EN to add a
// running XOR checksum output over all completed writes.
module instruction_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_stop,
    input  logic [1:0]    in_type,
    input  logic [4:0]    in_opcode,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs2,
    input  logic [4:0]    in_sa,
    input  logic [13:0]   in_imm,
    input  logic [23:0]   in_simm,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic [CW-1:0] words_written,
    output logic          done,
    output logic          err_illegal,
    output logic          err_full,
`ifdef CHECKSUM_EN
    output logic [31:0]   checksum,
`endif
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] T_R = 2'b00;
    localparam logic [1:0] T_J = 2'b01;
    localparam logic [1:0] T_I = 2'b10;
    localparam logic [1:0] T_S = 2'b11;

    state_t        state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] words_written_q, words_written_d;
    logic          done_q, done_d;
    logic          err_illegal_q, err_illegal_d;
    logic          err_full_q, err_full_d;
`ifdef CHECKSUM_EN
    logic [31:0]   csum_q, csum_d;
`endif

    logic          full;
    logic          last_slot;
    logic          wr_done;
    logic          accept;
    logic          word_legal;
    logic [31:0]   enc_word;

    function automatic logic opcode_legal(input logic [1:0] ty, input logic [4:0] op);
        logic ok;
        ok = 1'b0;
        case (ty)
            T_R:     ok = (op <= 5'd3);
            T_J:     ok = (op <= 5'd1);
            T_I:     ok = (op <= 5'd4);
            T_S:     ok = (op <= 5'd3);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Fields a type does not use are left zero rather than passed through.
    function automatic logic [31:0] encode_word(
        input logic        stop,
        input logic [1:0]  ty,
        input logic [4:0]  op,
        input logic [4:0]  rs1,
        input logic [4:0]  rd,
        input logic [4:0]  rs2,
        input logic [4:0]  sa,
        input logic [13:0] imm,
        input logic [23:0] simm
    );
        logic [31:0] w;
        w        = '0;
        w[31]    = stop;
        w[30:29] = ty;
        w[4:0]   = op;
        case (ty)
            T_R: begin
                w[9:5]   = rs1;
                w[14:10] = rd;
                w[19:15] = rs2;
            end
            T_J: begin
                w[28:5] = simm;
            end
            T_I: begin
                w[9:5]   = rs1;
                w[14:10] = rd;
                w[28:15] = imm;
            end
            default: begin
                w[9:5]   = rs1;
                w[14:10] = rd;
                w[19:15] = rs2;
                w[24:20] = sa;
            end
        endcase
        return w;
    endfunction

    // Handshakes: a bundle moves when in_valid && in_ready in the same cycle;
    // a write completes when mem_we && mem_ready, and mem_* hold until then.
    always_comb begin
        full       = (int'(words_written_q) + int'(mem_we_q)) == DEPTH;
        last_slot  = (int'(words_written_q) + 1) == DEPTH;
        wr_done    = mem_we_q && mem_ready;
        in_ready   = (state_q == S_RUN) && !full && (!mem_we_q || mem_ready);
        accept     = in_valid && in_ready;
        word_legal = opcode_legal(in_type, in_opcode);
        enc_word   = encode_word(in_stop, in_type, in_opcode, in_rs1, in_rd,
                                 in_rs2, in_sa, in_imm, in_simm);
    end

    always_comb begin
        state_d         = state_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        addr_d          = addr_q;
        words_written_d = words_written_q;
        done_d          = done_q;
        err_illegal_d   = err_illegal_q;
        err_full_d      = err_full_q;
`ifdef CHECKSUM_EN
        csum_d          = csum_q;
`endif

        if (wr_done) begin
            mem_we_d        = 1'b0;
            words_written_d = words_written_q + CW'(1);
`ifdef CHECKSUM_EN
            csum_d          = csum_q ^ mem_wdata_q;
`endif
        end

        // addr_q is the slot the next legal word lands in, so a completion and
        // a new accept in the same cycle still get distinct addresses.
        if (accept) begin
            if (word_legal) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = enc_word;
                addr_d      = addr_q + 32'd4;
            end else begin
                err_illegal_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d         = S_RUN;
                    words_written_d = '0;
                    done_d          = 1'b0;
                    err_illegal_d   = 1'b0;
                    err_full_d      = 1'b0;
                    addr_d          = BASE_ADDR;
`ifdef CHECKSUM_EN
                    csum_d          = '0;
`endif
                end
            end
            S_RUN: begin
                if (accept && word_legal && in_stop) begin
                    state_d = S_DRAIN;
                end else if (wr_done && last_slot) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    err_full_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (wr_done) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            addr_q          <= BASE_ADDR;
            words_written_q <= '0;
            done_q          <= 1'b0;
            err_illegal_q   <= 1'b0;
            err_full_q      <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            addr_q          <= addr_d;
            words_written_q <= words_written_d;
            done_q          <= done_d;
            err_illegal_q   <= err_illegal_d;
            err_full_q      <= err_full_d;
`ifdef CHECKSUM_EN
            csum_q          <= csum_d;
`endif
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign words_written = words_written_q;
    assign done          = done_q;
    assign err_illegal   = err_illegal_q;
    assign err_full      = err_full_q;
    assign dbg_state     = state_q;
`ifdef CHECKSUM_EN
    assign checksum      = csum_q;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed and randomized bench for instruction_encoder; expected writes come
// from an arithmetic encoding model and a per-session bookkeeping model.
module tb_instruction_encoder;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_stop;
    logic [1:0]    in_type;
    logic [4:0]    in_opcode, in_rs1, in_rd, in_rs2, in_sa;
    logic [13:0]   in_imm;
    logic [23:0]   in_simm;
    logic          mem_we;
    logic [31:0]   mem_addr, mem_wdata;
    logic          mem_ready;
    logic [CW-1:0] words_written;
    logic          done, err_illegal, err_full;
    logic [1:0]    dbg_state;
`ifdef CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    instruction_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_stop(in_stop),
        .in_type(in_type), .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rd(in_rd),
        .in_rs2(in_rs2), .in_sa(in_sa), .in_imm(in_imm), .in_simm(in_simm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .words_written(words_written), .done(done),
        .err_illegal(err_illegal), .err_full(err_full),
`ifdef CHECKSUM_EN
        .checksum(checksum),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset-free clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stop;
        logic [1:0]  ty;
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  sa;
        logic [13:0] imm;
        logic [23:0] simm;
    } fld_t;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_addr;
    int          m_words;
    bit          m_stop, m_illegal;
    logic [31:0] m_csum;
    logic [63:0] mon_e;
    bit          bp_en  = 1'b0;
    bit          mr_dir = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic fld_t mk(input int stop, input int ty, input int op, input int rs1,
                                input int rd, input int rs2, input int sa, input int imm,
                                input int simm);
        fld_t f;
        f.stop = 1'(stop);
        f.ty   = 2'(ty);
        f.op   = 5'(op);
        f.rs1  = 5'(rs1);
        f.rd   = 5'(rd);
        f.rs2  = 5'(rs2);
        f.sa   = 5'(sa);
        f.imm  = 14'(imm);
        f.simm = 24'(simm);
        return f;
    endfunction

    // Reference encoding: each field is weighted by 2**(its lowest bit).
    function automatic logic [31:0] ref_word(input fld_t f);
        logic [31:0] w;
        w = 32'(f.stop) * 32'h8000_0000 + 32'(f.ty) * 32'h2000_0000 + 32'(f.op);
        case (f.ty)
            2'd0: w = w + 32'(f.rs1) * 32'd32 + 32'(f.rd) * 32'd1024 + 32'(f.rs2) * 32'd32768;
            2'd1: w = w + 32'(f.simm) * 32'd32;
            2'd2: w = w + 32'(f.rs1) * 32'd32 + 32'(f.rd) * 32'd1024 + 32'(f.imm) * 32'd32768;
            default: w = w + 32'(f.rs1) * 32'd32 + 32'(f.rd) * 32'd1024
                            + 32'(f.rs2) * 32'd32768 + 32'(f.sa) * 32'd1048576;
        endcase
        return w;
    endfunction

    function automatic bit ref_legal(input fld_t f);
        int max_op[4];
        max_op = '{3, 1, 4, 3};
        return int'(f.op) <= max_op[f.ty];
    endfunction

    function automatic fld_t rnd_word(input bit legal_only, input bit allow_stop);
        fld_t f;
        f = mk(allow_stop ? int'($urandom_range(0, 3) == 0) : 0,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 16383)), int'($urandom & 32'h00FF_FFFF));
        if (legal_only) f.op = 5'(int'(f.op) % 2);
        return f;
    endfunction

    task automatic model_start();
        m_addr    = BASE;
        m_words   = 0;
        m_stop    = 1'b0;
        m_illegal = 1'b0;
        m_csum    = '0;
    endtask

    task automatic model_accept(input fld_t f);
        if (ref_legal(f)) begin
            exp_q.push_back({m_addr, ref_word(f)});
            m_addr  = m_addr + 32'd4;
            m_words = m_words + 1;
            if (f.stop) m_stop = 1'b1;
        end else begin
            m_illegal = 1'b1;
        end
    endtask

    // scoreboard: every completed write must match the oldest expected one
    always @(negedge clk) begin
        if (rst && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", mem_addr, mon_e[63:32]);
                check("wr_data", mem_wdata, mon_e[31:0]);
                m_csum = m_csum ^ mon_e[31:0];
            end
        end
    end

    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = bp_en ? ($urandom_range(0, 3) != 0) : mr_dir;
        end
    end

    // driver tasks; all inputs change 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input fld_t f);
        in_stop   = f.stop;
        in_type   = f.ty;
        in_opcode = f.op;
        in_rs1    = f.rs1;
        in_rd     = f.rd;
        in_rs2    = f.rs2;
        in_sa     = f.sa;
        in_imm    = f.imm;
        in_simm   = f.simm;
    endtask

    task automatic send_word(input fld_t f, input int bound, output bit ok);
        drive(f);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) model_accept(f);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_reached", 32'(done), 32'd1);
        step();
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mem_we) break;
        end
        check("drained", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    initial begin
        fld_t w1, w2, f;
        bit   ok;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3 rst = 1'b0;
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_words", 32'(words_written), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_illegal", 32'(err_illegal), 32'd0);
        check("rst_err_full", 32'(err_full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // session 1: R word then a J stop word
        do_start();
        send_word(mk(0, 0, 0, 1, 3, 2, 0, 0, 0), 20, ok);
        check("r_accept", 32'(ok), 32'd1);
        check("r_we_latency", 32'(mem_we), 32'd1);
        check("r_addr", mem_addr, BASE);
        check("r_data", mem_wdata, 32'h0001_0C20);
        send_word(mk(1, 1, 1, 0, 0, 0, 0, 0, 24'hFF_FFFF), 20, ok);
        check("j_accept", 32'(ok), 32'd1);
        check("j_data", mem_wdata, 32'hBFFF_FFE1);
        check("stop_in_ready", 32'(in_ready), 32'd0);
        check("stop_done_early", 32'(done), 32'd0);
        step();
        check("stop_done", 32'(done), 32'd1);
        check("stop_err_full", 32'(err_full), 32'd0);
        check("stop_words", 32'(words_written), 32'd2);
        check("stop_mem_we", 32'(mem_we), 32'd0);

        // session 2: I, S, ignored start, illegal drops, stop as DEPTH-th word
        do_start();
        check("s2_words_clear", 32'(words_written), 32'd0);
        check("s2_done_clear", 32'(done), 32'd0);
        send_word(mk(0, 2, 0, 4, 5, 0, 0, 14'h3FFF, 0), 20, ok);
        check("i_data", mem_wdata, 32'h5FFF_9480);
        send_word(mk(0, 3, 2, 1, 2, 3, 31, 0, 0), 20, ok);
        check("s_data", mem_wdata, 32'h61F1_8822);
        check("s_addr", mem_addr, BASE + 32'd4);
        wait_drain(20);
        check("seq_words", 32'(words_written), 32'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_words", 32'(words_written), 32'd2);
        check("start_ignored_ready", 32'(in_ready), 32'd1);
        send_word(mk(0, 0, 5, 1, 1, 1, 0, 0, 0), 20, ok);
        check("illegal_accept", 32'(ok), 32'd1);
        check("illegal_no_we", 32'(mem_we), 32'd0);
        check("illegal_flag", 32'(err_illegal), 32'd1);
        send_word(mk(0, 0, 3, 7, 8, 9, 0, 0, 0), 20, ok);
        check("after_illegal_addr", mem_addr, BASE + 32'd8);
        send_word(mk(1, 2, 7, 0, 0, 0, 0, 0, 0), 20, ok);
        check("illegal_stop_done", 32'(done), 32'd0);
        check("illegal_stop_ready", 32'(in_ready), 32'd1);
        send_word(mk(1, 3, 3, 2, 4, 6, 8, 0, 0), 20, ok);
        wait_done(20);
        check("last_stop_err_full", 32'(err_full), 32'd0);
        check("last_stop_words", 32'(words_written), 32'd4);
        check("illegal_sticky", 32'(err_illegal), 32'd1);

        // session 3: backpressure, back-to-back, then overfill
        do_start();
        mr_dir = 1'b0;
        w1 = rnd_word(1'b1, 1'b0);
        w2 = rnd_word(1'b1, 1'b0);
        send_word(w1, 20, ok);
        drive(w2);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_mem_we", 32'(mem_we), 32'd1);
            check("bp_mem_addr", mem_addr, BASE);
            check("bp_mem_wdata", mem_wdata, ref_word(w1));
        end
        step();
        mr_dir = 1'b1;
        send_word(w2, 20, ok);
        check("bp_next_we", 32'(mem_we), 32'd1);
        check("bp_next_addr", mem_addr, BASE + 32'd4);
        check("bp_next_data", mem_wdata, ref_word(w2));
        send_word(mk(0, 1, 9, 0, 0, 0, 0, 0, 1), 20, ok);
        for (int i = 0; i < 2; i++) begin
            send_word(rnd_word(1'b1, 1'b0), 20, ok);
            check("fill_accept", 32'(ok), 32'd1);
        end
        send_word(rnd_word(1'b1, 1'b0), 8, ok);
        check("fifth_rejected", 32'(ok), 32'd0);
        check("full_done", 32'(done), 32'd1);
        check("full_err_full", 32'(err_full), 32'd1);
        check("full_words", 32'(words_written), 32'd4);
        check("full_mem_we", 32'(mem_we), 32'd0);

        do_start();
        check("restart_words", 32'(words_written), 32'd0);
        check("restart_err_full", 32'(err_full), 32'd0);
        check("restart_err_illegal", 32'(err_illegal), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        send_word(mk(1, 2, 4, 1, 2, 0, 0, 100, 0), 20, ok);
        check("restart_addr", mem_addr, BASE);
        wait_done(20);

        // randomized sessions under random memory backpressure
        bp_en = 1'b1;
        for (int s = 0; s < 25; s++) begin
            do_start();
            while (!(m_stop || m_words == DEPTH)) begin
                f = rnd_word(1'b0, 1'b1);
                send_word(f, 60, ok);
                check("rnd_accept", 32'(ok), 32'd1);
                if (!ok) break;
            end
            wait_done(200);
            check("rnd_err_full", 32'(err_full), 32'(m_words == DEPTH && !m_stop));
            check("rnd_err_illegal", 32'(err_illegal), 32'(m_illegal));
            check("rnd_words", 32'(words_written), 32'(m_words));
            check("rnd_exp_empty", 32'(exp_q.size()), 32'd0);
`ifdef CHECKSUM_EN
            check("rnd_checksum", checksum, m_csum);
`endif
        end
        bp_en = 1'b0;

        // reset in the middle of a stalled write
        mr_dir = 1'b0;
        step();
        do_start();
        send_word(rnd_word(1'b1, 1'b0), 20, ok);
        check("mid_we_before", 32'(mem_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_words", 32'(words_written), 32'd0);
        exp_q.delete();
        step();
        rst = 1'b1;
        mr_dir = 1'b1;
        step();
        check("mid_rst_idle", 32'(dbg_state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
